// File: rtl/bcd_pkg.sv
// Shared BCD constants used by the BCD<->binary converters.
// The binary-to-BCD direction uses threshold 5 / +3; this direction uses threshold 8 / -3.
package bcd_pkg;

  localparam int         BCD_DIGIT_W   = 4;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [3:0] BCD_ADJ_THR   = 4'd8;
  localparam logic [3:0] BCD_ADJ       = 4'd3;

endpackage

// File: rtl/bcd2bin.sv
// Sequential BCD-to-binary converter (reverse double dabble), one conversion at a time.
// Start/Done handshake; Error flags a non-BCD digit or a value that does not fit in BIN_WIDTH bits.
module bcd2bin
  import bcd_pkg::*;
#(
  parameter int BIN_WIDTH  = 8,
  parameter int DEC_DIGITS = 2
) (
  input  logic                              Clk,
  input  logic                              Rst_n,
  input  logic [DEC_DIGITS*BCD_DIGIT_W-1:0] DataBCD,
  input  logic                              Start,
  output logic [BIN_WIDTH-1:0]              DataBin,
  output logic                              Busy,
  output logic                              Done,
  output logic                              Error
);

  localparam int BCD_W = DEC_DIGITS * BCD_DIGIT_W;
  localparam int IDX_W = (DEC_DIGITS > 1) ? $clog2(DEC_DIGITS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VALIDATE,
    ST_SHIFT,
    ST_SUB,
    ST_FINISH
  } state_e;

  state_e               state_q, state_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic [BIN_WIDTH-1:0] bin_q, bin_d;
  logic [IDX_W-1:0]     digit_idx_q, digit_idx_d;
  logic [7:0]           loop_count_q, loop_count_d;
  logic                 err_q, err_d;
  logic [BIN_WIDTH-1:0] data_bin_q, data_bin_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;

  logic [DEC_DIGITS-1:0]  digit_bad;
  logic [BCD_DIGIT_W-1:0] cur_digit;
  logic                   fin_err;

  for (genvar g = 0; g < DEC_DIGITS; g++) begin : g_digit_chk
    assign digit_bad[g] = bcd_q[g*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT;
  end

  assign cur_digit = bcd_q[digit_idx_q*BCD_DIGIT_W +: BCD_DIGIT_W];
  // A nonzero residue after all shifts means the value is >= 2**BIN_WIDTH.
  assign fin_err   = err_q | (|bcd_q);

  always_comb begin
    // NOTE: every signal gets a default here so no path can infer a latch.
    state_d      = state_q;
    bcd_d        = bcd_q;
    bin_d        = bin_q;
    digit_idx_d  = digit_idx_q;
    loop_count_d = loop_count_q;
    err_d        = err_q;
    data_bin_d   = data_bin_q;
    error_d      = error_q;
    done_d       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          bcd_d        = DataBCD;
          bin_d        = '0;
          loop_count_d = '0;
          digit_idx_d  = '0;
          state_d      = ST_VALIDATE;
        end
      end
      ST_VALIDATE: begin
        err_d   = |digit_bad;
        state_d = (|digit_bad) ? ST_FINISH : ST_SHIFT;
      end
      ST_SHIFT: begin
        {bcd_d, bin_d} = {bcd_q, bin_q} >> 1;
        loop_count_d   = loop_count_q + 8'd1;
        if (loop_count_q == 8'(BIN_WIDTH - 1)) begin
          state_d = ST_FINISH;
        end else begin
          digit_idx_d = '0;
          state_d     = ST_SUB;
        end
      end
      ST_SUB: begin
        if (cur_digit >= BCD_ADJ_THR) begin
          bcd_d[digit_idx_q*BCD_DIGIT_W +: BCD_DIGIT_W] = cur_digit - BCD_ADJ;
        end
        if (digit_idx_q == IDX_W'(DEC_DIGITS - 1)) begin
          state_d = ST_SHIFT;
        end else begin
          digit_idx_d = digit_idx_q + IDX_W'(1);
        end
      end
      ST_FINISH: begin
        done_d     = 1'b1;
        error_d    = fin_err;
        data_bin_d = fin_err ? '0 : bin_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q      <= ST_IDLE;
      bcd_q        <= '0;
      bin_q        <= '0;
      digit_idx_q  <= '0;
      loop_count_q <= '0;
      err_q        <= 1'b0;
      data_bin_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      bcd_q        <= bcd_d;
      bin_q        <= bin_d;
      digit_idx_q  <= digit_idx_d;
      loop_count_q <= loop_count_d;
      err_q        <= err_d;
      data_bin_q   <= data_bin_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign DataBin = data_bin_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Error   = error_q;

endmodule

// File: tb/tb_bcd2bin.sv
// Self-checking bench for bcd2bin: directed cases plus randomized BCD inputs on a
// 2-digit and a 3-digit instance, compared against a decimal-arithmetic reference model.
module tb_bcd2bin;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start2, start3;
  logic [7:0]  bcd2;
  logic [11:0] bcd3;
  logic [7:0]  bin2, bin3;
  logic        busy2, busy3, done2, done3, err2, err3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bcd2bin #(.BIN_WIDTH(8), .DEC_DIGITS(2)) u_dut2 (
    .Clk(clk), .Rst_n(rst_n), .DataBCD(bcd2), .Start(start2),
    .DataBin(bin2), .Busy(busy2), .Done(done2), .Error(err2)
  );

  bcd2bin #(.BIN_WIDTH(8), .DEC_DIGITS(3)) u_dut3 (
    .Clk(clk), .Rst_n(rst_n), .DataBCD(bcd3), .Start(start3),
    .DataBin(bin3), .Busy(busy3), .Done(done3), .Error(err3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Decimal value of the digits; invalid digit or value > 255 gives error with result 0.
  function automatic void ref_model(input int nd, input logic [11:0] bcd,
                                    output int val, output bit err, output int lat);
    logic [3:0] d;
    bit bad = 0;
    val = 0;
    for (int i = nd - 1; i >= 0; i--) begin
      d   = bcd[i*4 +: 4];
      bad = bad | (d > 4'd9);
      val = val * 10 + int'(d);
    end
    err = 0;
    if (bad) begin
      err = 1; val = 0; lat = 2;
    end else begin
      lat = 2 + 8 + 7 * nd;
      if (val > 255) begin
        err = 1; val = 0;
      end
    end
  endfunction

  // Call with time just after a rising edge; returns just after the edge that raised Done.
  task automatic convert(input int nd, input logic [11:0] bcd, input bit noise, input string tag);
    int  eval, elat, cyc;
    bit  eerr, seen;
    ref_model(nd, bcd, eval, eerr, elat);
    if (nd == 2) begin bcd2 = bcd[7:0]; start2 = 1'b1; end
    else         begin bcd3 = bcd;      start3 = 1'b1; end
    @(posedge clk); #1;
    start2 = 1'b0; start3 = 1'b0;
    check({tag, " busy_after_start"}, (nd == 2) ? busy2 : busy3, 1);
    cyc = 0; seen = 0;
    while (!seen && cyc < 100) begin
      if (noise) begin
        if (nd == 2) begin start2 = 1'($urandom); bcd2 = 8'($urandom);  end
        else         begin start3 = 1'($urandom); bcd3 = 12'($urandom); end
      end
      @(posedge clk); #1;
      cyc++;
      seen = (nd == 2) ? done2 : done3;
    end
    start2 = 1'b0; start3 = 1'b0;
    check({tag, " latency"}, cyc, elat);
    check({tag, " busy_at_done"}, (nd == 2) ? busy2 : busy3, 0);
    check({tag, " data_bin"}, (nd == 2) ? bin2 : bin3, eval);
    check({tag, " error"}, (nd == 2) ? err2 : err3, eerr);
  endtask

  initial begin
    int ndone;
    logic [11:0] b;
    rst_n = 1'b0; start2 = 1'b0; start3 = 1'b0; bcd2 = '0; bcd3 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset data_bin", {bin3, bin2}, 0);
    check("reset busy",  {busy3, busy2}, 0);
    check("reset done",  {done3, done2}, 0);
    check("reset error", {err3, err2}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    convert(2, 12'h099, 0, "t1_99");
    repeat (3) @(posedge clk);
    #1;
    check("t1 hold data_bin", bin2, 99);
    check("t1 hold done_low", done2, 0);

    convert(2, 12'h000, 0, "t2_00");
    convert(2, 12'h001, 0, "t2_01");
    convert(2, 12'h042, 0, "t2_42");

    convert(2, 12'h03A, 0, "t3_3A");
    repeat (3) @(posedge clk);
    #1;
    check("t3 hold error", err2, 1);

    convert(2, 12'h073, 1, "t5_noise_73");
    convert(2, 12'h086, 1, "t5_noise_86");

    // Reset partway through a conversion must abort it without a Done pulse.
    bcd2 = 8'h99; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("t6 reset data_bin", bin2, 0);
    check("t6 reset busy", busy2, 0);
    check("t6 reset error", err2, 0);
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done2) ndone++;
    end
    check("t6 no_done_after_abort", ndone, 0);
    convert(2, 12'h057, 0, "t6_57");

    convert(3, 12'h255, 0, "t4_255");
    convert(3, 12'h256, 0, "t4_256");
    convert(3, 12'h999, 0, "t4_999");
    convert(3, 12'h000, 0, "t4_000");

    for (int v = 0; v < 100; v++) begin
      b = 12'((v / 10) * 16 + (v % 10));
      convert(2, b, 0, $sformatf("exh2_%0d", v));
    end
    for (int k = 0; k < 60; k++) begin
      for (int d = 0; d < 3; d++) begin
        b[d*4 +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                   : 4'($urandom_range(0, 9));
      end
      convert(3, b, 0, $sformatf("rnd3_%03h", b));
      if (k % 4 == 0) convert(2, {4'h0, b[7:0]}, 0, $sformatf("rnd2_%02h", b[7:0]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
